multicycle_sequencer: RTL
=========================

Name: multicycle_sequencer

Overview:
- Multi-cycle control FSM for the 16-bit, 16-register datapath (register file, ALU, data memory).
- Fetches each instruction from an external instruction ROM and decodes it.
- Drives register-file, ALU and data-memory controls one phase per cycle.
- Resolves BNE and JUMP locally by updating the program counter.
- Replaces free-running enable and delay-based sequencing with an explicit state machine and a memory request/acknowledge handshake.

Parameters:
- PC_W, 8, program counter and instruction address width.
- MEM_TIMEOUT, 15, maximum cycles in MEM waiting for mem_ack before error halt.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  single-cycle pulse; begins execution at pc=0 when in IDLE.
- prog_len  in  PC_W  instruction count; execution completes when pc >= prog_len.
- instr_addr  out  PC_W  instruction ROM address; equals pc.
- instr_data  in  16  ROM data; combinational from instr_addr.
- rf_addr_a  out  4  register-file read address A = ir[11:8].
- rf_addr_b  out  4  register-file read address B = ir[7:4].
- rf_data_a  in  16  register-file read data A; valid 1 cycle after its address.
- rf_data_b  in  16  register-file read data B; valid 1 cycle after its address.
- rf_wr_en  out  1  register-file write strobe, 1 cycle.
- rf_wr_addr  out  4  register-file write address.
- rf_wr_sel  out  1  write source select: 0 = ALU result, 1 = memory load data.
- alu_op  out  4  ALU operation: 0 AND, 1 OR, 2 ADD, 6 SUB, 7 SLT.
- mem_req  out  1  data-memory request; held until acknowledged.
- mem_we  out  1  data-memory direction: 1 = store, 0 = load; valid while mem_req=1.
- mem_offset  out  4  data-memory address offset = ir[15:12].
- mem_ack  in  1  data-memory completion.
- busy  out  1  high in every state except IDLE and HALT.
- done  out  1  high in HALT after normal completion.
- error  out  1  high in HALT after illegal opcode or memory timeout.

Behaviour:
- Reset (asynchronous): state=IDLE, pc=0, ir=0. All outputs 0, including instr_addr. Any outstanding mem_req is dropped mid-handshake; a later mem_ack is ignored.
- States: IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT.
- IDLE: on start go to FETCH with pc=0; otherwise stay.
- FETCH: if pc >= prog_len go to HALT with done=1. Otherwise ir <= instr_data, go to DECODE.
- DECODE: drive rf_addr_a and rf_addr_b from ir; these stay stable until the next FETCH. Branch on opcode ir[3:0]:
  - 0, 1, 2, 6, 7: go to EXEC.
  - 8 (LW), 10 (SW): go to MEM.
  - 14 (BNE): go to EXEC.
  - 15 (JUMP): pc <= pc + sext(ir[15:4]) truncated to PC_W; go to FETCH.
  - 3, 4, 5, 9, 11, 12, 13: illegal; go to HALT with error=1 and no side effects.
- EXEC, ALU ops: alu_op = ir[3:0]; go to WB.
- EXEC, BNE: compare rf_data_a with rf_data_b. If unequal, pc <= pc + sext(ir[15:12]); otherwise pc <= pc+1. Go to FETCH. The offset is relative to the BNE's own address.
- MEM: mem_req=1, mem_we = (opcode==10), mem_offset=ir[15:12].
  - Request stays asserted and stable until mem_ack is sampled high. mem_ack in the first MEM cycle completes that cycle.
  - On ack: SW does pc <= pc+1 and goes to FETCH; LW goes to WB.
  - Timeout counter starts at 0 on entry. If no ack after MEM_TIMEOUT cycles, drop mem_req and go to HALT with error=1.
- WB: rf_wr_en=1 for exactly one cycle; pc <= pc+1; go to FETCH.
  - ALU op: rf_wr_addr=ir[15:12], rf_wr_sel=0.
  - LW: rf_wr_addr=ir[11:8], rf_wr_sel=1.
- Latency per instruction:
  - ALU op: 4 cycles (FETCH, DECODE, EXEC, WB).
  - LW: 4 + w cycles, where w = extra ack wait cycles.
  - SW: 3 + w cycles.
  - BNE: 3 cycles.
  - JUMP: 2 cycles.
- PC arithmetic is modulo 2^PC_W. Wrap-around is legal; a negative offset from pc=0 wraps to 2^PC_W-1, which then terminates via the prog_len check.
- HALT: busy=0; done or error held. start restarts from pc=0 and clears done and error.
- start while busy: ignored.
- Control outputs not listed for a state are 0 in that state.

Test Plan:
- Reset during MEM with mem_req=1 -> next edge all outputs 0, state IDLE. A mem_ack 2 cycles later causes no transition.
- Program [ADD r2=r2+r3 (0x2232)], prog_len=1, start -> rf_wr_en pulses on the 4th cycle after start with rf_wr_addr=2 and rf_wr_sel=0. done=1 on cycle 5.
- Loop [0x2232, 0xF24E (BNE r2,r4, offset -1)] with r3=2, r4=20, regfile model starting r2=0 -> exactly 10 ADD writebacks, then done. Cycle count = 10×4 + 10×3 + 1.
- JUMP 0x002F at pc=4 -> instr_addr=6 two cycles after fetching pc=4; instruction 5 is never fetched.
- LW 0x1208 with mem_ack delayed 3 cycles -> mem_req high for exactly 4 cycles with mem_we=0 and mem_offset=1, then WB with rf_wr_addr=2, rf_wr_sel=1. SW 0x100A with mem_ack held high -> mem_req for 1 cycle, mem_we=1, no rf_wr_en.
- Opcode 0x0003 -> error=1, no rf_wr_en and no mem_req. mem_ack never asserted on LW -> mem_req drops after 15 cycles, error=1. Subsequent start clears error.

Source files
------------

// File: rtl/multicycle_sequencer.sv
// rtl/multicycle_sequencer.sv - multi-cycle fetch/decode/execute control FSM for the 16-bit datapath

module multicycle_sequencer #(
  parameter int PC_W        = 8,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            start,
  input  logic [PC_W-1:0] prog_len,
  output logic [PC_W-1:0] instr_addr,
  input  logic [15:0]     instr_data,
  output logic [3:0]      rf_addr_a,
  output logic [3:0]      rf_addr_b,
  input  logic [15:0]     rf_data_a,
  input  logic [15:0]     rf_data_b,
  output logic            rf_wr_en,
  output logic [3:0]      rf_wr_addr,
  output logic            rf_wr_sel,
  output logic [3:0]      alu_op,
  output logic            mem_req,
  output logic            mem_we,
  output logic [3:0]      mem_offset,
  input  logic            mem_ack,
  output logic            busy,
  output logic            done,
  output logic            error
);

  // Wait counter only needs to reach MEM_TIMEOUT-1 before the timeout fires.
  localparam int CNT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;

  localparam logic [3:0] OP_AND  = 4'd0;
  localparam logic [3:0] OP_OR   = 4'd1;
  localparam logic [3:0] OP_ADD  = 4'd2;
  localparam logic [3:0] OP_SUB  = 4'd6;
  localparam logic [3:0] OP_SLT  = 4'd7;
  localparam logic [3:0] OP_LW   = 4'd8;
  localparam logic [3:0] OP_SW   = 4'd10;
  localparam logic [3:0] OP_BNE  = 4'd14;
  localparam logic [3:0] OP_JUMP = 4'd15;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB,
    S_HALT
  } state_t;

  state_t          state;
  logic [PC_W-1:0] pc;
  logic [15:0]     ir;
  logic [CNT_W-1:0] wait_cnt;

  logic [3:0]      opcode;
  logic [PC_W-1:0] jump_ofs;
  logic [PC_W-1:0] bne_ofs;
  logic [PC_W-1:0] pc_next_seq;

  // Branch/jump offsets are sign-extended and wrap modulo 2^PC_W.
  assign opcode      = ir[3:0];
  assign jump_ofs    = PC_W'({{20{ir[15]}}, ir[15:4]});
  assign bne_ofs     = PC_W'({{28{ir[15]}}, ir[15:12]});
  assign pc_next_seq = pc + PC_W'(1);

  // Register read addresses follow ir, so they settle in DECODE and hold until the next fetch.
  assign instr_addr = pc;
  assign rf_addr_a  = ir[11:8];
  assign rf_addr_b  = ir[7:4];

  // Sequencer: every control output is registered with the state it belongs to.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      pc         <= '0;
      ir         <= '0;
      wait_cnt   <= '0;
      rf_wr_en   <= 1'b0;
      rf_wr_addr <= '0;
      rf_wr_sel  <= 1'b0;
      alu_op     <= '0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_offset <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
    end else begin
      rf_wr_en   <= 1'b0;
      rf_wr_addr <= '0;
      rf_wr_sel  <= 1'b0;
      alu_op     <= '0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_offset <= '0;
      busy       <= 1'b1;
      done       <= 1'b0;
      error      <= 1'b0;

      case (state)
        S_IDLE: begin
          if (start) begin
            pc    <= '0;
            state <= S_FETCH;
          end else begin
            busy <= 1'b0;
          end
        end

        S_FETCH: begin
          if (pc >= prog_len) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= S_HALT;
          end else begin
            ir    <= instr_data;
            state <= S_DECODE;
          end
        end

        S_DECODE: begin
          case (opcode)
            OP_AND, OP_OR, OP_ADD, OP_SUB, OP_SLT: begin
              alu_op <= opcode;
              state  <= S_EXEC;
            end
            OP_BNE: begin
              state <= S_EXEC;
            end
            OP_LW, OP_SW: begin
              mem_req    <= 1'b1;
              mem_we     <= (opcode == OP_SW);
              mem_offset <= ir[15:12];
              wait_cnt   <= '0;
              state      <= S_MEM;
            end
            OP_JUMP: begin
              pc    <= pc + jump_ofs;
              state <= S_FETCH;
            end
            default: begin
              busy  <= 1'b0;
              error <= 1'b1;
              state <= S_HALT;
            end
          endcase
        end

        S_EXEC: begin
          if (opcode == OP_BNE) begin
            pc    <= (rf_data_a != rf_data_b) ? (pc + bne_ofs) : pc_next_seq;
            state <= S_FETCH;
          end else begin
            rf_wr_en   <= 1'b1;
            rf_wr_addr <= ir[15:12];
            rf_wr_sel  <= 1'b0;
            state      <= S_WB;
          end
        end

        S_MEM: begin
          if (mem_ack) begin
            if (opcode == OP_SW) begin
              pc    <= pc_next_seq;
              state <= S_FETCH;
            end else begin
              rf_wr_en   <= 1'b1;
              rf_wr_addr <= ir[11:8];
              rf_wr_sel  <= 1'b1;
              state      <= S_WB;
            end
          end else if (wait_cnt == CNT_W'(MEM_TIMEOUT - 1)) begin
            busy  <= 1'b0;
            error <= 1'b1;
            state <= S_HALT;
          end else begin
            wait_cnt   <= wait_cnt + CNT_W'(1);
            mem_req    <= 1'b1;
            mem_we     <= (opcode == OP_SW);
            mem_offset <= ir[15:12];
          end
        end

        S_WB: begin
          pc    <= pc_next_seq;
          state <= S_FETCH;
        end

        S_HALT: begin
          if (start) begin
            pc    <= '0;
            state <= S_FETCH;
          end else begin
            busy  <= 1'b0;
            done  <= done;
            error <= error;
          end
        end

        default: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
